traffic_light_sequencer: RTL and testbench

- Generates the four per-approach light signals `traffic0_color`..`traffic3_color` (1 = green, 0 = red) consumed by the VGA renderer, which also uses them to stop or release cars.
- Time-sequences two conflicting phases, north/south (lights 0/2) and east/west (lights 1/3), with an all-red clearance interval between them.
- Timing is counted in animation ticks derived from the same slow `animate_clk` the renderer uses.
- Supports an automatic cycle and a player-driven manual mode; freezes while the game is over.

---
 rtl/traffic_light_sequencer_pkg.sv | 21 ++
 rtl/traffic_light_sequencer_sync_edge_detect.sv | 32 +++
 rtl/traffic_light_sequencer.sv | 151 +++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_sequencer_pkg.sv
// Shared definitions for the intersection light sequencer and the renderer.
package traffic_light_sequencer_pkg;

  // Phase encoding, also exported on the phase output.
  typedef enum logic [1:0] {
    NS_GO  = 2'd0,
    NS_CLR = 2'd1,
    EW_GO  = 2'd2,
    EW_CLR = 2'd3
  } phase_t;

  // Light levels as the renderer interprets them.
  localparam logic LIGHT_GREEN = 1'b1;
  localparam logic LIGHT_RED   = 1'b0;

  // Light level for an approach whose green phase is go_phase.
  function automatic logic light_for(input phase_t cur, input phase_t go_phase);
    return (cur == go_phase) ? LIGHT_GREEN : LIGHT_RED;
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse appears three clk edges after the asynchronous input rises.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;
  logic pulse_reg;

  // Synchronize the level, remember last synced value, emit one-cycle rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg  <= 1'b0;
      sync_reg  <= 1'b0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      meta_reg  <= din;
      sync_reg  <= meta_reg;
      prev_reg  <= sync_reg;
      pulse_reg <= sync_reg & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/traffic_light_sequencer.sv
// Intersection light sequencer: alternates N/S and E/W green phases with an
// all-red clearance between them, counted in animation ticks. Supports an
// automatic cycle, request-driven manual mode, and a freeze on game over.
module traffic_light_sequencer
  import traffic_light_sequencer_pkg::*;
#(
  parameter int GREEN_TICKS     = 8,
  parameter int MIN_GREEN_TICKS = 3,
  parameter int CLEAR_TICKS     = 2,
  parameter int CNT_W           = 8
) (
  input  logic             dclk,
  input  logic             clr,
  input  logic             animate_clk,
  input  logic             game_over,
  input  logic             manual_en,
  input  logic             btn_ns,
  input  logic             btn_ew,
  output logic             traffic0_color,
  output logic             traffic1_color,
  output logic             traffic2_color,
  output logic             traffic3_color,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Edge-detected async inputs: index 0 = animate_clk, 1 = btn_ns, 2 = btn_ew.
  logic [2:0] edge_in;
  logic [2:0] edge_pulse;
  assign edge_in = {btn_ew, btn_ns, animate_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      sync_edge_detect u_sync_edge (
        .clk   (dclk),
        .rst_n (clr),
        .din   (edge_in[gi]),
        .pulse (edge_pulse[gi])
      );
    end
  endgenerate

  logic tick;
  logic ns_req;
  logic ew_req;
  assign tick   = edge_pulse[0];
  assign ns_req = edge_pulse[1];
  assign ew_req = edge_pulse[2];

  // Level-only inputs: index 0 = game_over, 1 = manual_en.
  logic [1:0] level_in;
  logic [1:0] level_meta_reg;
  logic [1:0] level_sync_reg;
  assign level_in = {manual_en, game_over};

  // Two-flop synchronizers for the level controls.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      level_meta_reg <= 2'b00;
      level_sync_reg <= 2'b00;
    end else begin
      level_meta_reg <= level_in;
      level_sync_reg <= level_meta_reg;
    end
  end

  logic frozen;
  logic manual;
  assign frozen = level_sync_reg[0];
  assign manual = level_sync_reg[1];

  phase_t           state_reg;
  phase_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             pending_ns_reg;
  logic             pending_ew_reg;
  logic             fire;
  logic             advance;

  assign advance = tick & ~frozen;

  // Exit condition and destination for the current phase.
  always_comb begin
    fire       = 1'b0;
    state_next = state_reg;
    case (state_reg)
      NS_GO: begin
        fire       = manual ? (pending_ew_reg && (cnt_reg >= MIN_LAST))
                            : (cnt_reg == GREEN_LAST);
        state_next = NS_CLR;
      end
      NS_CLR: begin
        fire       = (cnt_reg == CLEAR_LAST);
        state_next = EW_GO;
      end
      EW_GO: begin
        fire       = manual ? (pending_ns_reg && (cnt_reg >= MIN_LAST))
                            : (cnt_reg == GREEN_LAST);
        state_next = EW_CLR;
      end
      default: begin
        fire       = (cnt_reg == CLEAR_LAST);
        state_next = NS_GO;
      end
    endcase
  end

  // Phase FSM, tick counter and request latches; all hold while frozen.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      state_reg      <= EW_CLR;
      cnt_reg        <= '0;
      pending_ns_reg <= 1'b0;
      pending_ew_reg <= 1'b0;
    end else if (!frozen) begin
      if (advance) begin
        if (fire) begin
          state_reg <= state_next;
          cnt_reg   <= '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      // Entering a green phase consumes its request; that beats a new press.
      if (advance && fire && (state_next == NS_GO)) begin
        pending_ns_reg <= 1'b0;
      end else if (ns_req && (state_reg != NS_GO)) begin
        pending_ns_reg <= 1'b1;
      end
      if (advance && fire && (state_next == EW_GO)) begin
        pending_ew_reg <= 1'b0;
      end else if (ew_req && (state_reg != EW_GO)) begin
        pending_ew_reg <= 1'b1;
      end
    end
  end

  assign traffic0_color = light_for(state_reg, NS_GO);
  assign traffic2_color = light_for(state_reg, NS_GO);
  assign traffic1_color = light_for(state_reg, EW_GO);
  assign traffic3_color = light_for(state_reg, EW_GO);
  assign phase          = state_reg;
  assign tick_cnt       = cnt_reg;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer (narrow counter to reach saturation).
module tb_traffic_light_sequencer;

  localparam int CNT_W = 4;

  logic             dclk = 1'b0;
  logic             clr = 1'b0;
  logic             animate_clk = 1'b0;
  logic             game_over = 1'b0;
  logic             manual_en = 1'b0;
  logic             btn_ns = 1'b0;
  logic             btn_ew = 1'b0;
  logic             traffic0_color;
  logic             traffic1_color;
  logic             traffic2_color;
  logic             traffic3_color;
  logic [1:0]       phase;
  logic [CNT_W-1:0] tick_cnt;

  traffic_light_sequencer #(
    .GREEN_TICKS     (8),
    .MIN_GREEN_TICKS (3),
    .CLEAR_TICKS     (2),
    .CNT_W           (CNT_W)
  ) dut (
    .dclk           (dclk),
    .clr            (clr),
    .animate_clk    (animate_clk),
    .game_over      (game_over),
    .manual_en      (manual_en),
    .btn_ns         (btn_ns),
    .btn_ew         (btn_ew),
    .traffic0_color (traffic0_color),
    .traffic1_color (traffic1_color),
    .traffic2_color (traffic2_color),
    .traffic3_color (traffic3_color),
    .phase          (phase),
    .tick_cnt       (tick_cnt)
  );

  // 25 MHz pixel clock
  always #20 dclk = ~dclk;

  int total_checks = 0;
  int passed_checks = 0;

  typedef struct {
    logic man;
    logic go;
    logic bns;
    logic bew;
    int   ticks;
    int   ph;
    int   cnt;
    int   lights;
    int   pns;
    int   pew;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic man, input logic go, input logic bns,
                              input logic bew, input int ticks, input int ph,
                              input int cnt, input int lights, input int pns,
                              input int pew);
    vec_t v;
    v.man = man; v.go = go; v.bns = bns; v.bew = bew; v.ticks = ticks;
    v.ph = ph; v.cnt = cnt; v.lights = lights; v.pns = pns; v.pew = pew;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int lights_now();
    return {28'd0, traffic3_color, traffic2_color, traffic1_color, traffic0_color};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge dclk);
  endtask

  task automatic do_tick();
    @(negedge dclk);
    animate_clk = 1'b1;
    wait_cyc(8);
    animate_clk = 1'b0;
    wait_cyc(8);
  endtask

  task automatic press_ns();
    @(negedge dclk);
    btn_ns = 1'b1;
    wait_cyc(8);
    btn_ns = 1'b0;
    wait_cyc(8);
  endtask

  task automatic press_ew();
    @(negedge dclk);
    btn_ew = 1'b1;
    wait_cyc(8);
    btn_ew = 1'b0;
    wait_cyc(8);
  endtask

  task automatic chk_state(input string tag, input int ph, input int cnt,
                           input int lights, input int pns, input int pew);
    chk({tag, " phase"}, int'(phase), ph);
    chk({tag, " tick_cnt"}, int'(tick_cnt), cnt);
    chk({tag, " lights"}, lights_now(), lights);
    chk({tag, " pending_ns"}, int'(dut.pending_ns_reg), pns);
    chk({tag, " pending_ew"}, int'(dut.pending_ew_reg), pew);
  endtask

  initial begin
    // lights field = {t3,t2,t1,t0}; NS green = 5, EW green = 10
    vecs[0]  = mk(0, 0, 0, 0, 0,  3, 0,  0,  0, 0); // reset state
    vecs[1]  = mk(0, 0, 0, 0, 1,  3, 1,  0,  0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1,  0, 0,  5,  0, 0); // first NS_GO
    vecs[3]  = mk(0, 0, 0, 0, 7,  0, 7,  5,  0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1,  1, 0,  0,  0, 0); // 8 ticks green
    vecs[5]  = mk(0, 0, 0, 0, 1,  1, 1,  0,  0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1,  2, 0,  10, 0, 0); // EW_GO
    vecs[7]  = mk(0, 0, 0, 0, 4,  2, 4,  10, 0, 0);
    vecs[8]  = mk(0, 1, 1, 0, 20, 2, 4,  10, 0, 0); // frozen, press dropped
    vecs[9]  = mk(0, 0, 0, 0, 0,  2, 4,  10, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 3,  2, 7,  10, 0, 0); // resumes from 4
    vecs[11] = mk(0, 0, 0, 0, 1,  3, 0,  0,  0, 0);
    vecs[12] = mk(0, 0, 0, 0, 2,  0, 0,  5,  0, 0);
    vecs[13] = mk(1, 0, 0, 1, 0,  0, 0,  5,  0, 1); // manual, EW request
    vecs[14] = mk(1, 0, 0, 0, 2,  0, 2,  5,  0, 1); // min green not met
    vecs[15] = mk(1, 0, 0, 0, 1,  1, 0,  0,  0, 1);
    vecs[16] = mk(1, 0, 0, 0, 2,  2, 0,  10, 0, 0); // request consumed
    vecs[17] = mk(1, 0, 0, 1, 0,  2, 0,  10, 0, 0); // own-phase press ignored
    vecs[18] = mk(1, 0, 0, 0, 20, 2, 15, 10, 0, 0); // saturation
    vecs[19] = mk(1, 0, 1, 0, 1,  3, 0,  0,  1, 0);
    vecs[20] = mk(1, 0, 0, 0, 2,  0, 0,  5,  0, 0);
    vecs[21] = mk(1, 0, 1, 0, 20, 0, 15, 5,  0, 0); // stays NS_GO

    clr = 1'b0;
    wait_cyc(5);
    clr = 1'b1;
    wait_cyc(2);

    for (int i = 0; i < 22; i++) begin
      manual_en = vecs[i].man;
      game_over = vecs[i].go;
      wait_cyc(4);
      if (vecs[i].bns) press_ns();
      if (vecs[i].bew) press_ew();
      for (int t = 0; t < vecs[i].ticks; t++) do_tick();
      chk_state($sformatf("vec%0d", i), vecs[i].ph, vecs[i].cnt,
                vecs[i].lights, vecs[i].pns, vecs[i].pew);
      $display("vec%0d: ticks=%0d phase=%0d tick_cnt=%0d lights=%0d",
               i, vecs[i].ticks, phase, tick_cnt, lights_now());
    end

    // Latency: outputs change on the 4th dclk edge after the animate_clk rise.
    press_ew();
    @(negedge dclk);
    animate_clk = 1'b1;
    wait_cyc(3);
    chk("latency edge3 phase", int'(phase), 0);
    wait_cyc(1);
    chk("latency edge4 phase", int'(phase), 1);
    chk("latency edge4 lights", lights_now(), 0);
    wait_cyc(4);
    animate_clk = 1'b0;
    wait_cyc(8);
    $display("latency: phase=%0d tick_cnt=%0d", phase, tick_cnt);
    do_tick();
    do_tick();
    chk_state("enter_ew", 2, 0, 10, 0, 0);
    $display("enter_ew: phase=%0d tick_cnt=%0d", phase, tick_cnt);

    // Two ticks 1 us apart (25 dclk period each).
    for (int k = 0; k < 2; k++) begin
      @(negedge dclk);
      animate_clk = 1'b1;
      wait_cyc(12);
      animate_clk = 1'b0;
      wait_cyc(12);
    end
    wait_cyc(4);
    chk("two_ticks tick_cnt", int'(tick_cnt), 2);
    $display("two_ticks: tick_cnt=%0d", tick_cnt);

    // Asynchronous reset mid-EW_GO with a pending request.
    press_ns();
    chk("pre_reset pending_ns", int'(dut.pending_ns_reg), 1);
    @(posedge dclk);
    #7 clr = 1'b0;
    #1;
    chk_state("async_reset", 3, 0, 0, 0, 0);
    $display("async_reset: phase=%0d lights=%0d", phase, lights_now());
    @(negedge dclk);
    clr = 1'b1;
    wait_cyc(2);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
